// File: rtl/mem_access_unit_pkg.sv
// Shared types for the data-memory load/store unit: size codes,
// FSM states and a size-to-byte-count helper.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    RESP
  } state_e;

  function automatic logic [2:0] size_nbytes(logic [1:0] sz);
    logic [2:0] n;
    unique case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundles for the unit: request/response handshake (mau_req_if)
// and the word-wide data-memory port (mau_mem_if).
interface mau_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed,
    output req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed,
    input  req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

interface mau_mem_if;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;

  modport master (
    output mem_adr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata
  );

  modport slave (
    input  mem_adr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane datapath: load extract/extend and sub-word store merge.
// word_i is the word read at the request address (lane 0 = addr).
module mau_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  always_comb begin
    rdata_o  = word_i;
    merged_o = wdata_i;
    unique case (1'b1)
      (size_i == SZ_BYTE): begin
        rdata_o  = {{24{signed_i & word_i[7]}}, word_i[7:0]};
        merged_o = {word_i[31:8], wdata_i[7:0]};
      end
      (size_i == SZ_HALF): begin
        rdata_o  = {{16{signed_i & word_i[15]}}, word_i[15:0]};
        merged_o = {word_i[31:16], wdata_i[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the datapath and a word-write-only data
// memory. Ports: clk, rst, req (slave handshake), mem (master port).
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_BYTES = 65536
) (
  input logic        clk,
  input logic        rst,
  mau_req_if.slave   req,
  mau_mem_if.master  mem
);

  state_e      state_q;
  logic        we_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] adr_q;
  logic [31:0] mwdata_q;

  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic [32:0] end_addr;
  logic        bad;

  // 33-bit end address so addresses near 2^32 cannot wrap past the check
  assign end_addr = {1'b0, req.req_addr}
                  + {30'b0, size_nbytes(req.req_size)};

  always_comb begin
    bad = (end_addr > 33'(MEM_BYTES));
    unique case (req.req_size)
      SZ_BYTE: ;
      SZ_HALF: bad = bad | req.req_addr[0];
      SZ_WORD: bad = bad | (|req.req_addr[1:0]);
      default: bad = 1'b1;
    endcase
  end

  mau_lane_align u_align (
    .word_i   (mem.mem_rdata),
    .wdata_i  (wdata_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .rdata_o  (ld_data),
    .merged_o (st_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SZ_BYTE;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      adr_q    <= '0;
      mwdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req.req_valid) begin
            we_q     <= req.req_we;
            signed_q <= req.req_signed;
            size_q   <= req.req_size;
            wdata_q  <= req.req_wdata;
            adr_q    <= req.req_addr;
            err_q    <= bad;
            rdata_q  <= '0;
            if (bad) begin
              state_q <= RESP;
            end else if (!req.req_we) begin
              state_q <= RD;
            end else if (req.req_size == SZ_WORD) begin
              mwdata_q <= req.req_wdata;
              state_q  <= WR;
            end else begin
              state_q <= RMW_RD;
            end
          end
        end
        RD: begin
          rdata_q <= ld_data;
          state_q <= RESP;
        end
        RMW_RD: begin
          mwdata_q <= st_word;
          state_q  <= WR;
        end
        WR:      state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req.req_ready  = (state_q == IDLE);
  assign req.resp_valid = (state_q == RESP);
  assign req.resp_err   = err_q;
  assign req.resp_rdata = rdata_q;

  assign mem.mem_adr   = adr_q;
  assign mem.mem_wdata = mwdata_q;
  // gated by rst so a write can never land on a reset edge
  assign mem.mem_rd = ((state_q == RD) || (state_q == RMW_RD)) && !rst;
  assign mem.mem_wr = (state_q == WR) && !rst;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: a load/store unit between the single-cycle MIPS datapath and the byte-addressed, little-endian 64 KiB data memory.
- Accepts one word, halfword or byte load/store request per transaction over a valid/ready handshake.
- The memory port supports whole-word writes only, so sub-word stores run as read-modify-write.
- Loads are sign- or zero-extended (lb/lbu/lh/lhu/lw/sb/sh/sw).

Parameters:
MEM_BYTES, 65536, size of the data memory in bytes; any access with addr+nbytes > MEM_BYTES is rejected

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, the low 8/16/32 bits are used
resp_valid  output  1  one-cycle response pulse
resp_err  output  1  qualified by resp_valid: misaligned, illegal size or out of range
resp_rdata  output  32  qualified by resp_valid: extended load data; 0 for stores and errors
mem_adr  output  32  memory address
mem_wdata  output  32  memory write data
mem_rd  output  1  memory read enable; memory read data is combinational
mem_wr  output  1  memory write enable; memory writes on the rising edge
mem_rdata  input  32  memory read data, {b[a+3],b[a+2],b[a+1],b[a]}

Behaviour:
- Reset values: state IDLE, req_ready=1 (after reset), resp_valid=0, resp_err=0, resp_rdata=0, mem_adr=0, mem_wdata=0, mem_rd=0, mem_wr=0.
- mem_rd and mem_wr are Moore decodes of state and are ANDed with !rst, so no write ever lands on a reset edge.
- Request acceptance: a request is accepted when req_valid && req_ready in IDLE.
  - All request fields are latched into internal registers.
  - mem_adr is driven from the latched address.
- Error check at acceptance: error if size==11, half with addr[0]!=0, word with addr[1:0]!=0, or addr+nbytes > MEM_BYTES.
  - An error goes IDLE->RESP with resp_err=1, resp_rdata=0, and makes no memory access.
- States: IDLE, RD, RMW_RD, WR, RESP.
  - Load: IDLE->RD->RESP. In RD, mem_rd=1 and mem_rdata is captured at the cycle end. resp_valid is 2 cycles after acceptance.
  - Word store: IDLE->WR->RESP. In WR, mem_wr=1 and mem_wdata=req_wdata. resp_valid is 2 cycles after acceptance.
  - Sub-word store: IDLE->RMW_RD->WR->RESP. In RMW_RD, mem_rd=1 and the word is captured. In WR, the merged word is written. resp_valid is 3 cycles after acceptance.
  - The merge replaces byte lane 0 (byte) or lanes 1:0 (half) of the word read at req_addr. Lanes not being replaced are written back unchanged.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Load extension:
  - Byte: {{24{s&b[7]}}, b[7:0]}.
  - Half: {{16{s&h[15]}}, h[15:0]}.
  - Word: passed through; req_signed is ignored.
- Outside their active states: mem_rd=0 and mem_wr=0. mem_adr and mem_wdata hold their last values.
- req_ready=0 in every state except IDLE. A request arriving during RESP is accepted no earlier than the following IDLE cycle.
- Reset mid-operation in any state: next state IDLE, and the in-flight transaction is dropped. No resp_valid is produced and memory contents are unchanged.
- Back-to-back throughput: one word load or store every 3 cycles; one sub-word store every 4 cycles.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state enum IDLE/RD/RMW_RD/WR/RESP;
  - a function returning nbytes for a size.
- One combinational sub-module, mau_lane_align, provides:
  - the load extract/extend path: word, size, signed -> rdata;
  - the store merge path: old word, wdata, size -> new word.
- The FSM, request registers and error check stay in the top.

Test Plan:
- Reset: assert rst for 2 cycles mid-WR of a word store 0xDEADBEEF to 1000 -> memory at 1000 is unchanged; resp_valid is never seen; req_ready=1 after reset.
- Word load: memory at 1000 holds 32'd110; lw 1000 -> resp_valid 2 cycles after acceptance, resp_rdata=0x0000006E, resp_err=0; mem_rd high for exactly 1 cycle.
- Sub-word loads: memory at 1060 holds 0xFFFFFFFC.
  - lb 1060 signed -> 0xFFFFFFFC.
  - lbu -> 0x000000FC.
  - lh signed -> 0xFFFFFFFC.
  - lhu -> 0x0000FFFC.
- Sub-word store: memory at 1004 holds 0x11223344; sb 1004 data 0xAA -> 0x112233AA, response on cycle 3. Then sh 1004 data 0xBEEF -> 0x1122BEEF. mem_wr is high for exactly 1 cycle per store.
- Errors, each giving resp_err=1 one cycle after acceptance with no mem_rd or mem_wr:
  - lw at 1002;
  - lh at 1001;
  - size 11;
  - sw at 65533.
- Handshake: req_valid held high continuously with 3 word loads queued -> req_ready low between acceptances; acceptances 3 cycles apart; responses in order with correct data.
